// File: rtl/pre_if_stage_if.sv
// Instruction SRAM request channel between the pre-IF stage and the
// instruction memory (or its bridge).
//
// Signals:
//   inst_sram_req     master->slave  fetch request valid
//   inst_sram_wr      master->slave  write enable (always 0 for fetch)
//   inst_sram_size    master->slave  access size (2'd2 = word)
//   inst_sram_wstrb   master->slave  byte strobes (always 0 for fetch)
//   inst_sram_addr    master->slave  fetch address
//   inst_sram_wdata   master->slave  write data (always 0 for fetch)
//   inst_sram_addr_ok slave->master  request accepted this cycle
interface pre_if_stage_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok
  );
endinterface

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues one instruction-SRAM request at a
// time and holds the accepted request as an entry for the fetch stage.
// Redirects (writeback exception/ertn, or a taken branch) either retarget the
// PC directly or, while a request is waiting for addr_ok, are buffered and the
// in-flight request is marked for discard.
//
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   fs_allowin        fetch stage can take the held entry this cycle
//   br_bus            {br_taken, br_target[31:0]} from decode
//   ws_to_pfs_bus     {has_int, ex_era, ex_entry, final_ex, ertn_flush}
//   sram              instruction SRAM request channel (master side)
//   pfs_to_fs_valid   held entry valid
//   pfs_to_fs_bus     {discard, adef_ex, pc[31:0]}
//
// Build option: define PFS_ADEF_CHECK_EN to turn a misaligned fetch PC into an
// address-error entry instead of issuing a request. Without it the request
// address is word-aligned by force and adef_ex is always 0.
`ifndef BR_BUS_WD
`define BR_BUS_WD 33
`endif

module pre_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  fs_allowin,
  input  logic [`BR_BUS_WD-1:0] br_bus,
  input  logic [66:0]           ws_to_pfs_bus,
  pre_if_stage_if.master        sram,
  output logic                  pfs_to_fs_valid,
  output logic [33:0]           pfs_to_fs_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic [31:0] pc_r;
  logic        buf_valid;
  logic [31:0] buf_pc;
  logic        discard_pending;
  logic        hold_discard;
  logic        hold_adef;
  logic [31:0] hold_pc;

  logic        br_taken;
  logic [31:0] br_target;
  logic        final_ex;
  logic        ertn_flush;
  logic [31:0] ex_era;
  logic [31:0] ex_entry;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        misaligned;
  logic        capture;
  logic        unused_has_int;

  assign br_taken       = br_bus[32];
  assign br_target      = br_bus[31:0];
  assign unused_has_int = ws_to_pfs_bus[66];
  assign ex_era         = ws_to_pfs_bus[65:34];
  assign ex_entry       = ws_to_pfs_bus[33:2];
  assign final_ex       = ws_to_pfs_bus[1];
  assign ertn_flush     = ws_to_pfs_bus[0];

  // Writeback redirect has priority over a branch in the same cycle.
  assign redirect        = final_ex | br_taken;
  assign redirect_target = final_ex ? (ertn_flush ? ex_era : ex_entry) : br_target;

`ifdef PFS_ADEF_CHECK_EN
  assign misaligned          = (pc_r[1:0] != 2'b00);
  assign sram.inst_sram_addr = pc_r;
`else
  assign misaligned          = 1'b0;
  assign sram.inst_sram_addr = {pc_r[31:2], 2'b00};
`endif

  assign sram.inst_sram_wr    = 1'b0;
  assign sram.inst_sram_size  = 2'd2;
  assign sram.inst_sram_wstrb = 4'h0;
  assign sram.inst_sram_wdata = 32'h0;

  assign pfs_to_fs_valid = (state == HOLD);
  assign pfs_to_fs_bus   = {hold_discard, hold_adef, hold_pc};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // capture: this cycle's REQ ends and its entry moves into the hold register.
  // A misaligned PC (address-error build only) completes without a request.
  always_comb begin
    state_nxt          = state;
    sram.inst_sram_req = 1'b0;
    capture            = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (misaligned) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else begin
          sram.inst_sram_req = 1'b1;
          if (sram.inst_sram_addr_ok) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (fs_allowin) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_r            <= RESET_PC;
      buf_valid       <= 1'b0;
      buf_pc          <= 32'h0;
      discard_pending <= 1'b0;
      hold_discard    <= 1'b0;
      hold_adef       <= 1'b0;
      hold_pc         <= 32'h0;
    end else if (capture) begin
      // A redirect in the accepting cycle makes this entry wrong-path too.
      hold_discard    <= discard_pending | redirect;
      hold_adef       <= misaligned;
      hold_pc         <= pc_r;
      buf_valid       <= 1'b0;
      discard_pending <= 1'b0;
      if (redirect)       pc_r <= redirect_target;
      else if (buf_valid) pc_r <= buf_pc;
      else                pc_r <= pc_r + 32'd4;
    end else if (state == REQ) begin
      // The in-flight address must stay stable, so park the target; a later
      // redirect simply overwrites the parked one.
      if (redirect) begin
        buf_pc          <= redirect_target;
        buf_valid       <= 1'b1;
        discard_pending <= 1'b1;
      end
    end else begin
      if (redirect) begin
        pc_r <= redirect_target;
        if (state == HOLD) hold_discard <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pre_if_stage.sv
`timescale 1ns/1ps
`ifndef BR_BUS_WD
`define BR_BUS_WD 33
`endif

module tb_pre_if_stage;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  localparam logic [31:0] DECOY  = 32'h1c0bad00;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  logic                  fs_allowin = 1'b0;
  logic [`BR_BUS_WD-1:0] br_bus = '0;
  logic [66:0]           ws_bus = '0;
  logic                  pfs_to_fs_valid;
  logic [33:0]           pfs_to_fs_bus;

  pre_if_stage_if sram ();

  pre_if_stage #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .fs_allowin      (fs_allowin),
    .br_bus          (br_bus),
    .ws_to_pfs_bus   (ws_bus),
    .sram            (sram),
    .pfs_to_fs_valid (pfs_to_fs_valid),
    .pfs_to_fs_bus   (pfs_to_fs_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic aok, input logic allow, input logic br,
                       input logic [31:0] btgt, input logic fex, input logic ertn,
                       input logic [31:0] era, input logic [31:0] entry, input logic hint);
    sram.inst_sram_addr_ok = aok;
    fs_allowin             = allow;
    br_bus                 = {br, btgt};
    ws_bus                 = {hint, era, entry, fex, ertn};
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        aok, allow, br;
    logic [31:0] btgt;
    logic        fex, ertn;
    logic [31:0] xtgt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid, edisc;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic aok, input logic allow, input logic br,
                              input logic [31:0] btgt, input logic fex, input logic ertn,
                              input logic [31:0] xtgt, input logic ereq, input logic [31:0] eaddr,
                              input logic evalid, input logic edisc, input logic [31:0] epc);
    vec_t v;
    v.aok = aok; v.allow = allow; v.br = br; v.btgt = btgt;
    v.fex = fex; v.ertn = ertn; v.xtgt = xtgt;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.edisc = edisc; v.epc = epc;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  // The model tracks: whether fetching has started, the next address to fetch,
  // at most one parked redirect target, whether the outstanding request is
  // already wrong-path, and a queue (0 or 1 deep) of entries awaiting fetch.
  bit          m_started;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  bit          m_wrong;
  logic [33:0] m_held[$];

  function automatic bit mis(input logic [31:0] pc);
`ifdef PFS_ADEF_CHECK_EN
    return pc[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] req_addr(input logic [31:0] pc);
`ifdef PFS_ADEF_CHECK_EN
    return pc;
`else
    return {pc[31:2], 2'b00};
`endif
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_pc      = RST_PC;
    m_pend.delete();
    m_wrong   = 0;
    m_held.delete();
  endtask

  task automatic model_step(input logic aok, input logic allow, input logic br,
                            input logic [31:0] btgt, input logic fex, input logic ertn,
                            input logic [31:0] era, input logic [31:0] entry);
    logic        redir;
    logic [31:0] tgt;
    logic [33:0] e;
    redir = fex | br;
    tgt   = fex ? (ertn ? era : entry) : btgt;
    if (!m_started) begin
      m_started = 1;
      if (redir) m_pc = tgt;
    end else if (m_held.size() != 0) begin
      if (redir) begin
        m_pc = tgt;
        e = m_held[0];
        e[33] = 1'b1;
        m_held[0] = e;
      end
      if (allow) m_held.delete();
    end else if (aok || mis(m_pc)) begin
      m_held.push_back({m_wrong | redir, mis(m_pc), m_pc});
      if (redir)                  m_pc = tgt;
      else if (m_pend.size() > 0) m_pc = m_pend.pop_front();
      else                        m_pc = m_pc + 32'd4;
      m_pend.delete();
      m_wrong = 0;
    end else if (redir) begin
      m_pend.delete();
      m_pend.push_back(tgt);
      m_wrong = 1;
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    repeat (2) tick();

    // reset state and tied-off write channel
    chk("reset_req",   34'(sram.inst_sram_req), 34'd0);
    chk("reset_valid", 34'(pfs_to_fs_valid),    34'd0);
    chk("reset_bus",   pfs_to_fs_bus,           34'd0);
    chk("tie_wr",      34'(sram.inst_sram_wr),    34'd0);
    chk("tie_size",    34'(sram.inst_sram_size),  34'd2);
    chk("tie_wstrb",   34'(sram.inst_sram_wstrb), 34'd0);
    chk("tie_wdata",   34'(sram.inst_sram_wdata), 34'd0);
    resetn = 1'b1;

    //          aok alw br btgt          fex ertn xtgt         req eaddr         vld dsc epc
    tbl.push_back(mk(1,1,0,32'h0,        0,0,32'h0,        1,32'h1c000000, 0,0,32'h0));
    tbl.push_back(mk(1,1,0,32'h0,        0,0,32'h0,        0,32'h0,        1,0,32'h1c000000));
    tbl.push_back(mk(1,1,0,32'h0,        0,0,32'h0,        1,32'h1c000004, 0,0,32'h0));
    tbl.push_back(mk(0,1,1,32'h1c000100, 0,0,32'h0,        1,32'h1c000004, 0,0,32'h0));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        1,32'h1c000004, 0,0,32'h0));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        1,32'h1c000004, 0,0,32'h0));
    tbl.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0,32'h0,        1,1,32'h1c000004));
    tbl.push_back(mk(1,1,0,32'h0,        0,0,32'h0,        1,32'h1c000100, 0,0,32'h0));
    tbl.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0,32'h0,        1,0,32'h1c000100));
    tbl.push_back(mk(1,0,1,32'h1c000200, 1,0,32'h1c008000, 0,32'h0,        1,1,32'h1c000100));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,0,0,32'h0,      0,0,32'h0,        0,32'h0,        1,1,32'h1c000100));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        1,32'h1c008000, 0,0,32'h0));
    tbl.push_back(mk(1,0,0,32'h0,        1,1,32'h1c000040, 0,32'h0,        1,1,32'h1c008000));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        1,32'h1c000040, 0,0,32'h0));
    tbl.push_back(mk(1,0,1,32'hfffffffc, 0,0,32'h0,        0,32'h0,        1,1,32'h1c000040));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        1,32'hfffffffc, 0,0,32'h0));
    tbl.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0,32'h0,        1,0,32'hfffffffc));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        1,32'h00000000, 0,0,32'h0));
    tbl.push_back(mk(0,1,1,32'h1c000300, 0,0,32'h0,        1,32'h00000000, 0,0,32'h0));
    tbl.push_back(mk(0,1,1,32'h1c000400, 0,0,32'h0,        1,32'h00000000, 0,0,32'h0));
    tbl.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0,32'h0,        1,1,32'h00000000));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        1,32'h1c000400, 0,0,32'h0));
    tbl.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0,32'h0,        1,0,32'h1c000400));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].aok, tbl[i].allow, tbl[i].br, tbl[i].btgt, tbl[i].fex, tbl[i].ertn,
            tbl[i].ertn ? tbl[i].xtgt : DECOY, tbl[i].ertn ? DECOY : tbl[i].xtgt, 1'b0);
      tick();
      chk($sformatf("vec%0d_req", i),   34'(sram.inst_sram_req), 34'(tbl[i].ereq));
      chk($sformatf("vec%0d_valid", i), 34'(pfs_to_fs_valid),    34'(tbl[i].evalid));
      if (tbl[i].ereq)
        chk($sformatf("vec%0d_addr", i), 34'(sram.inst_sram_addr), 34'(tbl[i].eaddr));
      if (tbl[i].evalid)
        chk($sformatf("vec%0d_bus", i), pfs_to_fs_bus, {tbl[i].edisc, 1'b0, tbl[i].epc});
    end

    // Reset asserted while a request waits for addr_ok.
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rst_mid_req_before", 34'(sram.inst_sram_req), 34'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_req_async", 34'(sram.inst_sram_req), 34'd0);
    chk("rst_mid_valid",     34'(pfs_to_fs_valid),    34'd0);
    chk("rst_mid_bus",       pfs_to_fs_bus,           34'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("rst_release_req",  34'(sram.inst_sram_req),  34'd1);
    chk("rst_release_addr", 34'(sram.inst_sram_addr), 34'(RST_PC));

    // Branch to a misaligned target.
    drive(0, 1, 1, 32'h1c000102, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("adef_prev_bus", pfs_to_fs_bus, {1'b1, 1'b0, RST_PC});
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
`ifdef PFS_ADEF_CHECK_EN
    chk("adef_noreq", 34'(sram.inst_sram_req), 34'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("adef_valid", 34'(pfs_to_fs_valid), 34'd1);
    chk("adef_bus",   pfs_to_fs_bus, {1'b0, 1'b1, 32'h1c000102});
`else
    chk("adef_req",  34'(sram.inst_sram_req),  34'd1);
    chk("adef_addr", 34'(sram.inst_sram_addr), 34'(32'h1c000100));
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("adef_valid", 34'(pfs_to_fs_valid), 34'd1);
    chk("adef_bus",   pfs_to_fs_bus, {1'b0, 1'b0, 32'h1c000102});
`endif

    // Randomized run against the reference model.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    model_reset();
    for (int c = 0; c < 800; c++) begin
      logic        aok, allow, br, fex, ertn, hint, exp_req;
      logic [31:0] btgt, era, entry;
      aok   = ($urandom_range(0, 9) < 6);
      allow = ($urandom_range(0, 9) < 7);
      br    = ($urandom_range(0, 9) == 0);
      fex   = ($urandom_range(0, 19) == 0);
      ertn  = $urandom_range(0, 1) == 1;
      hint  = $urandom_range(0, 1) == 1;
      btgt  = ($urandom_range(0, 7) == 0) ? 32'hfffffffc : ($urandom() & 32'hfffffffc);
      era   = $urandom() & 32'hfffffffc;
      entry = $urandom() & 32'hfffffffc;
      drive(aok, allow, br, btgt, fex, ertn, era, entry, hint);
      tick();
      model_step(aok, allow, br, btgt, fex, ertn, era, entry);
      exp_req = m_started && (m_held.size() == 0) && !mis(m_pc);
      chk($sformatf("rnd%0d_req", c),   34'(sram.inst_sram_req), 34'(exp_req));
      chk($sformatf("rnd%0d_valid", c), 34'(pfs_to_fs_valid),    34'(m_held.size() != 0));
      if (exp_req)
        chk($sformatf("rnd%0d_addr", c), 34'(sram.inst_sram_addr), 34'(req_addr(m_pc)));
      if (m_held.size() != 0)
        chk($sformatf("rnd%0d_bus", c), pfs_to_fs_bus, m_held[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
